// File: rtl/ristretto_if_prefetch_buffer_pkg.sv
// IF-stage shared types, default sizing and circular-index helper for the
// instruction prefetch buffer.
package ristretto_if_prefetch_buffer_pkg;

    localparam int unsigned IF_XLEN            = 32;
    localparam int unsigned IF_BUF_DEPTH       = 4;
    localparam int unsigned IF_MAX_OUTSTANDING = 2;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] instr;
        logic               err;
    } if_fetch_entry_t;

    // Successor of a circular index; depth need not be a power of two.
    function automatic int unsigned circ_next(input int unsigned idx, input int unsigned depth);
        return (idx == depth - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/ristretto_circ_buffer.sv
// Register-array circular FIFO with read/write pointers and an entry count.
module ristretto_circ_buffer
    import ristretto_if_prefetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = IF_BUF_DEPTH,
    parameter int unsigned WIDTH = 2 * IF_XLEN + 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             push_i,
    input  logic [WIDTH-1:0]                 wdata_i,
    input  logic                             pop_i,
    output logic [WIDTH-1:0]                 rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;

    // Storage, pointers and count; clear drops all entries without touching data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_i) begin
                mem_r[wr_ptr_r] <= wdata_i;
                wr_ptr_r        <= PW'(circ_next(32'(wr_ptr_r), DEPTH));
            end
            if (pop_i) begin
                rd_ptr_r <= PW'(circ_next(32'(rd_ptr_r), DEPTH));
            end
            case ({push_i, pop_i})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata_o = mem_r[rd_ptr_r];
    assign count_o = count_r;

endmodule

// File: rtl/ristretto_if_prefetch_buffer_chk.sv
// Protocol and overflow properties for the instruction prefetch buffer.
module ristretto_if_prefetch_buffer_chk #(
    parameter int unsigned DEPTH = 4
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    input logic                       flush_i,
    input logic                       req_issue_i,
    input logic                       push_i,
    input logic [$clog2(DEPTH+1)-1:0] count_i
);

    a_no_issue_in_flush: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(flush_i && req_issue_i))
        else $error("req_issue_i asserted together with flush_i");

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && (count_i == ($clog2(DEPTH+1))'(DEPTH))))
        else $error("push into full prefetch buffer");

endmodule

// File: rtl/ristretto_if_prefetch_buffer.sv
// Instruction prefetch buffer: credit-based request gating, post-flush drop of
// stale responses and optional same-cycle fall-through to decode.
module ristretto_if_prefetch_buffer
    import ristretto_if_prefetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH           = IF_BUF_DEPTH,
    parameter int unsigned XLEN            = IF_XLEN,
    parameter int unsigned MAX_OUTSTANDING = IF_MAX_OUTSTANDING,
    parameter bit          FALL_THROUGH    = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    output logic                       req_allow_o,
    input  logic                       req_issue_i,
    input  logic                       rsp_valid_i,
    input  logic [XLEN-1:0]            rsp_pc_i,
    input  logic [XLEN-1:0]            rsp_instr_i,
    input  logic                       rsp_err_i,
    output logic                       dec_valid_o,
    input  logic                       dec_ready_i,
    output logic [XLEN-1:0]            dec_pc_o,
    output logic [XLEN-1:0]            dec_instr_o,
    output logic                       dec_err_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            err;
    } entry_t;

    logic [OW-1:0] outstanding_r;
    logic [OW-1:0] drop_cnt_r;
    logic [CW-1:0] count_s;
    logic [SW-1:0] credit_use_s;
    entry_t        head_s;
    entry_t        rsp_entry_s;
    entry_t        dec_entry_s;
    logic          rsp_live_s;
    logic          bypass_s;
    logic          dec_valid_s;
    logic          push_s;
    logic          pop_s;

    assign rsp_entry_s = {rsp_pc_i, rsp_instr_i, rsp_err_i};

    // Response acceptance, fall-through bypass, pop and credit decisions.
    always_comb begin
        rsp_live_s   = rsp_valid_i && (drop_cnt_r == '0) && !flush_i;
        bypass_s     = FALL_THROUGH && (count_s == '0) && rsp_live_s;
        dec_valid_s  = !flush_i && ((count_s != '0) || bypass_s);
        pop_s        = !flush_i && (count_s != '0) && dec_ready_i;
        // A bypassed entry taken by decode in the same cycle never lands in storage.
        push_s       = rsp_live_s && !(bypass_s && dec_ready_i);
        credit_use_s = SW'(count_s) + SW'(outstanding_r - drop_cnt_r);
        req_allow_o  = !flush_i && (outstanding_r < OW'(MAX_OUTSTANDING))
                       && (credit_use_s < SW'(DEPTH));
        dec_entry_s  = !dec_valid_s ? '0 : ((count_s != '0) ? head_s : rsp_entry_s);
    end

    // In-flight request count and the number of stale responses still to discard.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_r <= '0;
            drop_cnt_r    <= '0;
        end else begin
            outstanding_r <= outstanding_r + OW'(req_issue_i) - OW'(rsp_valid_i);
            if (flush_i) begin
                drop_cnt_r <= outstanding_r - OW'(rsp_valid_i);
            end else if (rsp_valid_i && (drop_cnt_r != '0)) begin
                drop_cnt_r <= drop_cnt_r - OW'(1);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    ristretto_circ_buffer #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (flush_i),
        .push_i  (push_s),
        .wdata_i (rsp_entry_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .count_o (count_s)
    );

    ristretto_if_prefetch_buffer_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .req_issue_i (req_issue_i),
        .push_i      (push_s),
        .count_i     (count_s)
    );

    assign dec_valid_o = dec_valid_s;
    assign dec_pc_o    = dec_entry_s.pc;
    assign dec_instr_o = dec_entry_s.instr;
    assign dec_err_o   = dec_entry_s.err;
    assign occupancy_o = count_s;

endmodule

// File: tb/tb_ristretto_if_prefetch_buffer.sv
// Bench for ristretto_if_prefetch_buffer: three instances (depth 4 latched,
// depth 4 fall-through, depth 3 latched) against a queue-level reference model.
module tb_ristretto_if_prefetch_buffer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flush_d [3];
    logic        issue_d [3];
    logic        rv_d    [3];
    logic        err_d   [3];
    logic        rdy_d   [3];
    logic [31:0] pc_d    [3];
    logic [31:0] ins_d   [3];

    logic        allow_q [3];
    logic        dv_q    [3];
    logic        derr_q  [3];
    logic [31:0] dpc_q   [3];
    logic [31:0] dins_q  [3];
    logic [2:0]  occ_q   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned DP = (g == 2) ? 3 : 4;
        localparam bit          FT = (g == 1);
        logic                       allow_w, dv_w, derr_w;
        logic [31:0]                dpc_w, dins_w;
        logic [$clog2(DP+1)-1:0]    occ_w;

        ristretto_if_prefetch_buffer #(
            .DEPTH(DP), .XLEN(32), .MAX_OUTSTANDING(2), .FALL_THROUGH(FT)
        ) dut (
            .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_d[g]),
            .req_allow_o(allow_w), .req_issue_i(issue_d[g]),
            .rsp_valid_i(rv_d[g]), .rsp_pc_i(pc_d[g]), .rsp_instr_i(ins_d[g]),
            .rsp_err_i(err_d[g]), .dec_valid_o(dv_w), .dec_ready_i(rdy_d[g]),
            .dec_pc_o(dpc_w), .dec_instr_o(dins_w), .dec_err_o(derr_w),
            .occupancy_o(occ_w)
        );

        assign allow_q[g] = allow_w;
        assign dv_q[g]    = dv_w;
        assign derr_q[g]  = derr_w;
        assign dpc_q[g]   = dpc_w;
        assign dins_q[g]  = dins_w;
        assign occ_q[g]   = 3'(occ_w);
    end

    int errors = 0;
    int checks = 0;

    // Reference model: a plain array queue per instance plus request bookkeeping.
    int          m_depth [3] = '{4, 4, 3};
    bit          m_ft    [3] = '{1'b0, 1'b1, 1'b0};
    int          m_cnt   [3];
    int          m_out   [3];
    int          m_drop  [3];
    logic [64:0] m_q     [3][8];

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_out[k] = 0; m_drop[k] = 0;
        end
    endfunction

    function automatic bit model_credit(input int k);
        return (m_out[k] < 2) && (m_cnt[k] + m_out[k] - m_drop[k] < m_depth[k]);
    endfunction

    function automatic void model_outs(input int k, output bit allow, output bit v, output logic [64:0] e);
        bit byp;
        allow = !flush_d[k] && model_credit(k);
        byp   = m_ft[k] && (m_cnt[k] == 0) && rv_d[k] && (m_drop[k] == 0);
        v     = !flush_d[k] && ((m_cnt[k] > 0) || byp);
        if (!v)               e = '0;
        else if (m_cnt[k] > 0) e = m_q[k][0];
        else                  e = {pc_d[k], ins_d[k], err_d[k]};
    endfunction

    function automatic void model_step();
        bit acc, byp;
        for (int k = 0; k < 3; k++) begin
            byp = m_ft[k] && (m_cnt[k] == 0) && rv_d[k] && (m_drop[k] == 0) && !flush_d[k];
            if (flush_d[k]) begin
                m_cnt[k]  = 0;
                m_drop[k] = m_out[k] - int'(rv_d[k]);
            end else begin
                acc = rv_d[k] && (m_drop[k] == 0);
                if (rv_d[k] && (m_drop[k] > 0)) m_drop[k]--;
                if (!(byp && rdy_d[k])) begin
                    if ((m_cnt[k] > 0) && rdy_d[k]) begin
                        for (int j = 0; j < 7; j++) m_q[k][j] = m_q[k][j+1];
                        m_cnt[k]--;
                    end
                    if (acc) begin
                        m_q[k][m_cnt[k]] = {pc_d[k], ins_d[k], err_d[k]};
                        m_cnt[k]++;
                    end
                end
            end
            m_out[k] = m_out[k] + int'(issue_d[k]) - int'(rv_d[k]);
        end
    endfunction

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            flush_d[k] = 1'b0; issue_d[k] = 1'b0; rv_d[k] = 1'b0; err_d[k] = 1'b0;
            rdy_d[k] = 1'b0; pc_d[k] = '0; ins_d[k] = '0;
        end
    endtask

    task automatic drive(input int k, input logic f, input logic iss, input logic rv,
                         input logic [31:0] pc, input logic e, input logic rdy);
        flush_d[k] = f; issue_d[k] = iss; rv_d[k] = rv; pc_d[k] = pc;
        ins_d[k] = pc ^ 32'h1357_9BDF; err_d[k] = e; rdy_d[k] = rdy;
    endtask

    task automatic drive_a(input logic f, input logic iss, input logic rv,
                           input logic [31:0] pc, input logic e, input logic rdy);
        drive(0, f, iss, rv, pc, e, rdy);
        drive(1, f, iss, rv, pc, e, rdy);
    endtask

    // Scoreboard for the current cycle's inputs, then clock edge and model update.
    task automatic tick();
        bit ea, ev;
        logic [64:0] ee;
        for (int k = 0; k < 3; k++) begin
            model_outs(k, ea, ev, ee);
            checks += 4;
            if (allow_q[k] !== ea) begin errors++; $display("FAIL model_allow[%0d] t=%0t got=%b want=%b", k, $time, allow_q[k], ea); end
            if (dv_q[k] !== ev) begin errors++; $display("FAIL model_valid[%0d] t=%0t got=%b want=%b", k, $time, dv_q[k], ev); end
            if ({dpc_q[k], dins_q[k], derr_q[k]} !== ee) begin errors++;
                $display("FAIL model_data[%0d] t=%0t got=%h want=%h", k, $time, {dpc_q[k], dins_q[k], derr_q[k]}, ee); end
            if (occ_q[k] !== 3'(m_cnt[k])) begin errors++; $display("FAIL model_occ[%0d] t=%0t got=%0d want=%0d", k, $time, occ_q[k], m_cnt[k]); end
        end
        @(posedge clk);
        model_step();
        #1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks += 3;
            if (dv_q[k] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got=%b want=0", k, dv_q[k]); end
            if (occ_q[k] !== 3'd0) begin errors++; $display("FAIL reset_occ[%0d] got=%0d want=0", k, occ_q[k]); end
            if (dpc_q[k] !== 32'd0) begin errors++; $display("FAIL reset_pc[%0d] got=%h want=0", k, dpc_q[k]); end
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (allow_q[k] !== 1'b1) begin errors++; $display("FAIL reset_allow[%0d] got=%b want=1", k, allow_q[k]); end
        end
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive_a(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0); #1;
            checks++;
            if (allow_q[0] !== 1'b1) begin errors++; $display("FAIL fill_allow i=%0d got=%b want=1", i, allow_q[0]); end
            tick();
            @(negedge clk); drive_a(1'b0, 1'b0, 1'b1, 32'(4 * i), 1'b0, 1'b0); #1;
            tick();
        end
        @(negedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            checks += 2;
            if (occ_q[k] !== 3'd4) begin errors++; $display("FAIL fill_occ[%0d] got=%0d want=4", k, occ_q[k]); end
            if (allow_q[k] !== 1'b0) begin errors++; $display("FAIL full_allow[%0d] got=%b want=0", k, allow_q[k]); end
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive_a(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1); #1;
            for (int k = 0; k < 2; k++) begin
                checks += 2;
                if (dv_q[k] !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] i=%0d got=%b want=1", k, i, dv_q[k]); end
                if (dpc_q[k] !== 32'(4 * i)) begin errors++; $display("FAIL drain_pc[%0d] i=%0d got=%h want=%h", k, i, dpc_q[k], 32'(4 * i)); end
            end
            tick();
        end
    endtask

    task automatic test_fall_through();
        @(negedge clk); drive_a(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1); #1; tick();
        @(negedge clk); drive_a(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1); #1;
        checks += 3;
        if (dv_q[1] !== 1'b1) begin errors++; $display("FAIL ft_same_valid got=%b want=1", dv_q[1]); end
        if (dpc_q[1] !== 32'h100) begin errors++; $display("FAIL ft_same_pc got=%h want=100", dpc_q[1]); end
        if (dv_q[0] !== 1'b0) begin errors++; $display("FAIL noft_same_valid got=%b want=0", dv_q[0]); end
        tick();
        @(negedge clk); drive_a(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1); #1;
        checks += 4;
        if (occ_q[1] !== 3'd0) begin errors++; $display("FAIL ft_occ got=%0d want=0", occ_q[1]); end
        if (dv_q[1] !== 1'b0) begin errors++; $display("FAIL ft_next_valid got=%b want=0", dv_q[1]); end
        if (dv_q[0] !== 1'b1) begin errors++; $display("FAIL noft_next_valid got=%b want=1", dv_q[0]); end
        if (dpc_q[0] !== 32'h100) begin errors++; $display("FAIL noft_next_pc got=%h want=100", dpc_q[0]); end
        tick();
    endtask

    task automatic test_flush_drop();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive_a(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0); #1; tick();
        end
        @(negedge clk); drive_a(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0); #1; tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive_a(1'b0, 1'b0, 1'b1, 32'(32'h40 + 4 * i), 1'b0, 1'b0); #1;
            checks += 2;
            if (dv_q[1] !== 1'b0) begin errors++; $display("FAIL drop_valid i=%0d got=%b want=0", i, dv_q[1]); end
            if (occ_q[0] !== 3'd0) begin errors++; $display("FAIL drop_occ i=%0d got=%0d want=0", i, occ_q[0]); end
            tick();
        end
        @(negedge clk); drive_a(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0); #1; tick();
        @(negedge clk); drive_a(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0); #1; tick();
        @(negedge clk); drive_a(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1); #1;
        for (int k = 0; k < 2; k++) begin
            checks += 2;
            if (dpc_q[k] !== 32'h200) begin errors++; $display("FAIL redirect_pc[%0d] got=%h want=200", k, dpc_q[k]); end
            if (occ_q[k] !== 3'd1) begin errors++; $display("FAIL redirect_occ[%0d] got=%0d want=1", k, occ_q[k]); end
        end
        tick();
    endtask

    task automatic test_flush_collide();
        @(negedge clk); drive_a(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0); #1; tick();
        @(negedge clk); drive_a(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0); #1; tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive_a(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0); #1; tick();
        end
        @(negedge clk); drive_a(1'b1, 1'b0, 1'b1, 32'h304, 1'b0, 1'b1); #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dv_q[k] !== 1'b0) begin errors++; $display("FAIL collide_valid[%0d] got=%b want=0", k, dv_q[k]); end
        end
        tick();
        @(negedge clk); drive_a(1'b0, 1'b0, 1'b1, 32'h308, 1'b0, 1'b0); #1;
        checks += 2;
        if (dv_q[1] !== 1'b0) begin errors++; $display("FAIL collide_drop_valid got=%b want=0", dv_q[1]); end
        if (occ_q[0] !== 3'd0) begin errors++; $display("FAIL collide_occ got=%0d want=0", occ_q[0]); end
        tick();
        @(negedge clk); drive_a(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0); #1; tick();
        @(negedge clk); drive_a(1'b0, 1'b0, 1'b1, 32'h30C, 1'b0, 1'b1); #1;
        checks++;
        if (dv_q[1] !== 1'b1) begin errors++; $display("FAIL collide_after_valid got=%b want=1", dv_q[1]); end
        tick();
        @(negedge clk); drive_a(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1); #1;
        checks++;
        if (dpc_q[0] !== 32'h30C) begin errors++; $display("FAIL collide_after_pc got=%h want=30c", dpc_q[0]); end
        tick();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_a(1'b0, 1'b1, 1'b1, 32'(32'h400 + 4 * i), 1'b0, 1'b0);
            if (i < 2) drive(2, 1'b0, 1'b1, 1'b1, 32'(32'h800 + 4 * i), 1'b0, 1'b0);
            #1; tick();
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive_a(1'b0, 1'b1, 1'b1, 32'(32'h400 + 4 * (i + 3)), 1'b0, 1'b1);
            drive(2, 1'b0, 1'b1, 1'b1, 32'(32'h800 + 4 * (i + 2)), 1'b0, 1'b1);
            #1;
            checks += 5;
            if (allow_q[0] !== 1'b1) begin errors++; $display("FAIL stream_allow i=%0d got=%b want=1", i, allow_q[0]); end
            if (occ_q[0] !== 3'd3) begin errors++; $display("FAIL stream_occ4 i=%0d got=%0d want=3", i, occ_q[0]); end
            if (dpc_q[0] !== 32'(32'h400 + 4 * i)) begin errors++; $display("FAIL stream_pc4 i=%0d got=%h want=%h", i, dpc_q[0], 32'(32'h400 + 4 * i)); end
            if (occ_q[2] !== 3'd2) begin errors++; $display("FAIL stream_occ3 i=%0d got=%0d want=2", i, occ_q[2]); end
            if (dpc_q[2] !== 32'(32'h800 + 4 * i)) begin errors++; $display("FAIL stream_pc3 i=%0d got=%h want=%h", i, dpc_q[2], 32'(32'h800 + 4 * i)); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
            #1; tick();
        end
    endtask

    task automatic test_error_and_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive_a(1'b0, 1'b1, 1'b1, 32'(32'h500 + 4 * i), (i == 1), 1'b0); #1; tick();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive_a(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1); #1;
            checks += 2;
            if (derr_q[0] !== 1'(i == 1)) begin errors++; $display("FAIL err_flag i=%0d got=%b want=%b", i, derr_q[0], (i == 1)); end
            if (dpc_q[0] !== 32'(32'h500 + 4 * i)) begin errors++; $display("FAIL err_pc i=%0d got=%h want=%h", i, dpc_q[0], 32'(32'h500 + 4 * i)); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive_a(1'b0, 1'b1, 1'b1, 32'(32'h600 + 4 * i), 1'b0, 1'b0); #1; tick();
        end
        @(negedge clk); drive_a(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0); #1; tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks += 2;
            if (dv_q[k] !== 1'b0) begin errors++; $display("FAIL midreset_valid[%0d] got=%b want=0", k, dv_q[k]); end
            if (occ_q[k] !== 3'd0) begin errors++; $display("FAIL midreset_occ[%0d] got=%0d want=0", k, occ_q[k]); end
        end
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] pend_a[$];
        logic [31:0] pend_b[$];
        logic [31:0] npc_a = 32'h1000;
        logic [31:0] npc_b = 32'h2000;
        logic        f, iss, rv, e, rdy;
        logic [31:0] pc;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            f   = ($urandom_range(0, 19) == 0);
            rv  = (pend_a.size() > 0) && ($urandom_range(0, 2) != 0);
            pc  = rv ? pend_a.pop_front() : 32'd0;
            e   = rv && ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            iss = !f && model_credit(0) && model_credit(1) && ($urandom_range(0, 1) == 1);
            if (iss) begin pend_a.push_back(npc_a); npc_a += 32'd4; end
            if (f) npc_a = {$urandom_range(0, 65535), 2'b00} & 32'h0003_FFFC;
            drive_a(f, iss, rv, pc, e, rdy);
            f   = ($urandom_range(0, 24) == 0);
            rv  = (pend_b.size() > 0) && ($urandom_range(0, 1) == 1);
            pc  = rv ? pend_b.pop_front() : 32'd0;
            e   = rv && ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            iss = !f && model_credit(2) && ($urandom_range(0, 2) != 0);
            if (iss) begin pend_b.push_back(npc_b); npc_b += 32'd4; end
            if (f) npc_b = 32'h2000 + {$urandom_range(0, 4095), 2'b00};
            drive(2, f, iss, rv, pc, e, rdy);
            #1; tick();
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rv = (pend_a.size() > 0);
            pc = rv ? pend_a.pop_front() : 32'd0;
            drive_a(1'b0, 1'b0, rv, pc, 1'b0, 1'b1);
            rv = (pend_b.size() > 0);
            pc = rv ? pend_b.pop_front() : 32'd0;
            drive(2, 1'b0, 1'b0, rv, pc, 1'b0, 1'b1);
            #1; tick();
        end
        @(negedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (occ_q[k] !== 3'd0) begin errors++; $display("FAIL random_drained[%0d] got=%0d want=0", k, occ_q[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_fall_through();
        test_flush_drop();
        test_flush_collide();
        test_stream();
        test_error_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
